instr_mem_boot: RTL and testbench
=================================

Name: instr_mem_boot

Overview:
- Parametrised instruction memory for the RISC-V core, successor to the flat fetch ROM.
- After reset, an FSM first clears the array to NOP, then bulk-loads the program over a valid/ready stream (testbench or UART loader), then serves fetches.
- Fetches use a byte-addressed PC, have registered one-cycle latency, and flag misaligned or out-of-range accesses.
- Sits between the PC register and the decode stage.

Parameters:
- DATA_W, 32, instruction word width.
- DEPTH, 1024, number of words; a power of two is not required.
- PC_W, 32, PC width (byte address).
- NOP_WORD, 32'h00000013, fill and substitute word (addi x0,x0,0).

Ports:
- SYS_clk  in  1  single clock; all logic on rising edge.
- SYS_reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  load word present.
- ld_data  in  DATA_W  load word; written to consecutive addresses from 0.
- ld_last  in  1  qualifies the final load word.
- ld_ready  out  1  high only in LOAD.
- fetch_req  in  1  fetch request, sampled when fetch_ready=1.
- PC  in  PC_W  byte address of the fetch.
- fetch_ready  out  1  high only in RUN.
- instruction  out  DATA_W  registered fetch data.
- instr_valid  out  1  one-cycle pulse; instruction is valid.
- misaligned  out  1  registered with instr_valid; PC[1:0]!=0.
- out_of_range  out  1  registered with instr_valid; PC>>2 >= DEPTH.
- boot_done  out  1  high in RUN.
- load_count  out  $clog2(DEPTH+1)  number of words loaded.

Behaviour:
- Reset values: every output 0 (instruction=0, not NOP). FSM goes to CLEAR and the address counter to 0. Reset takes effect asynchronously at any time, including mid-CLEAR, mid-LOAD or with a fetch in flight. The in-flight fetch is discarded and no instr_valid follows it.
- CLEAR:
  - Write NOP_WORD to mem[cnt] each cycle, cnt 0..DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  - Then go to LOAD with cnt=0.
  - ld_ready=0; ld traffic is ignored.
- LOAD:
  - ld_ready=1. A transfer occurs on ld_valid&&ld_ready: mem[cnt]<=ld_data, cnt++, load_count<=cnt+1.
  - Go to RUN on a transfer with ld_last=1, or on the transfer that writes word DEPTH-1 (overflow guard; later words are never accepted).
  - ld_last on a cycle without ld_valid is ignored.
  - The RUN transition registers on the same edge as the final write. ld_ready falls the following cycle.
- RUN:
  - boot_done=1 and fetch_ready=1. ld_* inputs are ignored; the memory is never written in RUN.
  - On fetch_req at edge N, at edge N+1: instr_valid=1, misaligned and out_of_range updated, and instruction as follows:
    - mem[PC>>2] if both flags are 0;
    - NOP_WORD if either flag is 1 (both flags may assert together).
  - Back-to-back fetches give one result per cycle.
  - Without fetch_req, instr_valid=0; instruction and the flags hold their last values.
- Word index is PC[PC_W-1:2]; the range compare uses the full index width, with no wrap-around.
- The FSM is one-way (CLEAR→LOAD→RUN); only reset re-enters CLEAR.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits; the extra bit is the even parity of the word, computed on every write (CLEAR and LOAD).
  - On fetch, recomputed parity is compared with the stored bit. A mismatch drives output parity_err=1 with instr_valid, and instruction=NOP_WORD.
  - parity_err resets to 0.
- Undefined: no parity bit and no parity_err port. Array width is exactly DATA_W.

Decomposition:
- Package imem_pkg holds the FSM state enum (ST_CLEAR, ST_LOAD, ST_RUN), the NOP constant, and the localparam for the index width.
- One sub-module, imem_array: a single-port synchronous-write, registered-read RAM (DEPTH x width). The FSM multiplexes its address and write enable. The fetch flags and the NOP substitution stay in the top level.

Test Plan:
- Reset, then DEPTH=16 with no load words and ld_last on word 0 → CLEAR takes 16 cycles; fetch PC=0x8 → instruction=0x00000013, flags 0.
- Load 3 words 0x00500093, 0x00108113, 0xFFFFFFFF with ld_last on the 3rd → load_count=3, boot_done=1. Fetches at PC=0,4,8 back-to-back → those words on 3 consecutive cycles. PC=0xC → NOP.
- Stall ld_valid mid-stream, and toggle ld_last without ld_valid → no extra writes; load_count increments only on transfers.
- Load 20 words into DEPTH=16 with no ld_last → 16 accepted, ld_ready low after the 16th, words 17-20 never written.
- Fetch PC=0x6 → misaligned=1, NOP. Fetch PC=0x40 (DEPTH=16) → out_of_range=1, NOP. Fetch PC=0x42 → both flags 1.
- Assert SYS_reset mid-LOAD and again with fetch_req high in RUN → outputs 0 immediately, instr_valid stays 0, CLEAR restarts. With IMEM_PARITY_EN, force a bit flip in the array → parity_err=1, NOP.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory (instr_mem_boot).
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } imem_state_e;

    localparam logic [31:0]  IMEM_NOP        = 32'h0000_0013;
    localparam int unsigned  IMEM_DEPTH_DFLT = 1024;
    localparam int unsigned  IMEM_BYTE_OFF_W = 2;

    // Word-index width for a given depth; at least one bit even for a single-word array.
    function automatic int unsigned imem_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port RAM: synchronous write, registered read that holds its value when not enabled.
module imem_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_boot.sv
// Instruction memory with clear/load/run boot sequencer and flagged one-cycle fetches.
// Optional macro IMEM_PARITY_EN adds a stored even-parity bit and a parity_err output.
module instr_mem_boot
    import imem_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = IMEM_DEPTH_DFLT,
    parameter int unsigned       PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = IMEM_NOP
) (
    input  logic                       SYS_clk,
    input  logic                       SYS_reset,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    input  logic                       fetch_req,
    input  logic [PC_W-1:0]            PC,
    output logic                       fetch_ready,
    output logic [DATA_W-1:0]          instruction,
    output logic                       instr_valid,
    output logic                       misaligned,
    output logic                       out_of_range,
    output logic                       boot_done,
`ifdef IMEM_PARITY_EN
    output logic                       parity_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0] load_count
);

    localparam int unsigned AW    = imem_idx_w(DEPTH);
    localparam int unsigned LC_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = PC_W - IMEM_BYTE_OFF_W;
`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [LC_W-1:0]   load_count_q, load_count_d;
    logic              valid_q, valid_d;
    logic              mis_q, mis_d;
    logic              oor_q, oor_d;

    logic              mem_we, mem_re;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] wr_word;
    logic [MEM_W-1:0]  mem_wdata, mem_rdata;

    logic [IDX_W-1:0]  fetch_idx;
    logic              fetch_mis, fetch_oor;
    logic              bad_word;

    assign fetch_idx = PC[PC_W-1:IMEM_BYTE_OFF_W];
    assign fetch_mis = |PC[IMEM_BYTE_OFF_W-1:0];
    assign fetch_oor = (fetch_idx >= DEPTH_IDX);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_count_d = load_count_q;
        valid_d      = 1'b0;
        mis_d        = mis_q;
        oor_d        = oor_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = cnt_q;
        wr_word      = NOP_WORD;
        ld_ready     = 1'b0;
        fetch_ready  = 1'b0;
        boot_done    = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we       = 1'b1;
                    wr_word      = ld_data;
                    cnt_d        = cnt_q + AW'(1);
                    load_count_d = LC_W'(cnt_q) + LC_W'(1);
                    // The last array slot closes the load even without ld_last.
                    if (ld_last || (cnt_q == LAST_ADDR)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                fetch_ready = 1'b1;
                boot_done   = 1'b1;
                if (fetch_req) begin
                    mem_re   = 1'b1;
                    // Out-of-range indices may not fit the array; read a safe slot instead.
                    mem_addr = fetch_oor ? '0 : fetch_idx[AW-1:0];
                    valid_d  = 1'b1;
                    mis_d    = fetch_mis;
                    oor_d    = fetch_oor;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            load_count_q <= '0;
            valid_q      <= 1'b0;
            mis_q        <= 1'b0;
            oor_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_count_q <= load_count_d;
            valid_q      <= valid_d;
            mis_q        <= mis_d;
            oor_q        <= oor_d;
        end
    end

`ifdef IMEM_PARITY_EN
    assign mem_wdata  = {^wr_word, wr_word};
    assign parity_err = ~mis_q & ~oor_q & (mem_rdata[DATA_W] != ^mem_rdata[DATA_W-1:0]);
    assign bad_word   = mis_q | oor_q | parity_err;
`else
    assign mem_wdata  = wr_word;
    assign bad_word   = mis_q | oor_q;
`endif

    imem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (SYS_clk),
        .rst   (SYS_reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Read register and flags both reset to 0, so instruction is 0 (not NOP) out of reset.
    assign instruction  = bad_word ? NOP_WORD : mem_rdata[DATA_W-1:0];
    assign instr_valid  = valid_q;
    assign misaligned   = mis_q;
    assign out_of_range = oor_q;
    assign load_count   = load_count_q;

endmodule

// File: tb/tb_instr_mem_boot.sv
// Randomized self-checking bench for instr_mem_boot (DEPTH=16) against a word-array model.
module tb_instr_mem_boot;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        fetch_req = 1'b0;
    logic [31:0] PC = '0;
    logic        fetch_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        misaligned;
    logic        out_of_range;
    logic        boot_done;
    logic [4:0]  load_count;
`ifdef IMEM_PARITY_EN
    logic        parity_err;
`else
    logic        parity_err;
    assign parity_err = 1'b0;
`endif

    instr_mem_boot #(
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .PC_W     (32),
        .NOP_WORD (NOP)
    ) u_dut (
        .SYS_clk      (SYS_clk),
        .SYS_reset    (SYS_reset),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .fetch_req    (fetch_req),
        .PC           (PC),
        .fetch_ready  (fetch_ready),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .boot_done    (boot_done),
`ifdef IMEM_PARITY_EN
        .parity_err   (parity_err),
`endif
        .load_count   (load_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    int checks = 0;
    int failures = 0;

    // Reference model: what the program memory should hold and how far the load has got.
    logic [31:0] m_mem [DEPTH];
    int          m_cnt;
    bit          m_loading;
    bit          m_run;
    logic [31:0] last_instr;
    bit          last_mis;
    bit          last_oor;
    logic [31:0] fq[$];

    logic [42:0] outs_all;
    assign outs_all = {instruction, instr_valid, misaligned, out_of_range, ld_ready,
                       fetch_ready, boot_done, load_count};

    task automatic step();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic model_boot();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
        m_cnt = 0;
        m_loading = 0;
        m_run = 0;
        last_instr = '0;
        last_mis = 0;
        last_oor = 0;
    endtask

    task automatic apply_reset();
        SYS_reset = 1'b1;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        fetch_req = 1'b0;
        step();
        SYS_reset = 1'b0;
        model_boot();
    endtask

    // Expects exactly DEPTH cycles of clear; ld traffic offered meanwhile must be ignored.
    task automatic wait_clear();
        int cyc = 0;
        while (!ld_ready && cyc < 100) begin
            ld_valid = $urandom_range(0, 1);
            ld_data = $urandom;
            ld_last = $urandom_range(0, 1);
            step();
            cyc++;
        end
        ld_valid = 1'b0;
        ld_last = 1'b0;
        checks++;
        if (cyc != DEPTH) begin
            failures++;
            $display("FAIL clear_cycles: got %0d expected %0d", cyc, DEPTH);
        end
        checks++;
        if (load_count !== 5'd0 || boot_done !== 1'b0) begin
            failures++;
            $display("FAIL clear_no_write: load_count=%0d boot_done=%b expected 0/0",
                     load_count, boot_done);
        end
        m_loading = 1;
    endtask

    task automatic drive_ld(input bit v, input logic [31:0] d, input bit last);
        ld_valid = v;
        ld_data = d;
        ld_last = last;
        checks++;
        if (ld_ready !== m_loading) begin
            failures++;
            $display("FAIL ld_ready: got %b expected %b", ld_ready, m_loading);
        end
        step();
        if (v && m_loading) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (last || m_cnt == DEPTH) begin
                m_loading = 0;
                m_run = 1;
            end
        end
        checks++;
        if (load_count !== 5'(m_cnt) || boot_done !== m_run) begin
            failures++;
            $display("FAIL load_state: load_count=%0d boot_done=%b expected %0d/%b",
                     load_count, boot_done, m_cnt, m_run);
        end
    endtask

    // Drains fq; gaps=1 inserts random idle cycles where outputs must hold.
    task automatic run_fetches(input bit gaps);
        logic [31:0] cur_pc;
        bit          cur_req;
        bit          e_mis, e_oor;
        logic [31:0] e_ins;
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL fetch_ready: got %b expected 1", fetch_ready);
        end
        while (fq.size() > 0) begin
            if (!gaps || $urandom_range(0, 3) != 0) begin
                cur_pc = fq.pop_front();
                cur_req = 1;
            end else begin
                cur_pc = $urandom;
                cur_req = 0;
            end
            PC = cur_pc;
            fetch_req = cur_req;
            step();
            if (cur_req) begin
                e_mis = (cur_pc % 4) != 0;
                e_oor = (cur_pc / 4) >= DEPTH;
                e_ins = (e_mis || e_oor) ? NOP : m_mem[cur_pc / 4];
                checks++;
                if (instr_valid !== 1'b1 || instruction !== e_ins || misaligned !== e_mis ||
                    out_of_range !== e_oor || parity_err !== 1'b0) begin
                    failures++;
                    $display({"FAIL fetch pc=%h: valid=%b ins=%h mis=%b oor=%b perr=%b ",
                              "expected 1 %h %b %b 0"}, cur_pc, instr_valid, instruction,
                             misaligned, out_of_range, parity_err, e_ins, e_mis, e_oor);
                end
                last_instr = e_ins;
                last_mis = e_mis;
                last_oor = e_oor;
            end else begin
                checks++;
                if (instr_valid !== 1'b0 || instruction !== last_instr ||
                    misaligned !== last_mis || out_of_range !== last_oor) begin
                    failures++;
                    $display("FAIL idle_hold: valid=%b ins=%h mis=%b oor=%b expected 0 %h %b %b",
                             instr_valid, instruction, misaligned, out_of_range,
                             last_instr, last_mis, last_oor);
                end
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        SYS_reset = 1'b1;
        ld_valid = 1'b1;
        ld_last = 1'b1;
        fetch_req = 1'b1;
        PC = $urandom;
        step();
        step();
        checks++;
        if (outs_all !== '0 || parity_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs_all);
        end
        fetch_req = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        SYS_reset = 1'b0;
        model_boot();
    endtask

    task automatic test_clear_single();
        wait_clear();
        drive_ld(1'b1, $urandom, 1'b1);
        drive_ld(1'b1, $urandom, 1'b1);
        ld_valid = 1'b0;
        fq = '{32'h8, 32'h0, 32'h8, 32'h4};
        run_fetches(1'b0);
    endtask

    task automatic test_load_stall();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093;
        words[1] = 32'h0010_8113;
        words[2] = 32'hFFFF_FFFF;
        apply_reset();
        wait_clear();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
                drive_ld(1'b0, $urandom, $urandom_range(0, 1));
            end
            drive_ld(1'b1, words[i], i == 2);
        end
        for (int i = 0; i < 3; i++) drive_ld(1'b1, $urandom, 1'b1);
        ld_valid = 1'b0;
        fq = '{32'h0, 32'h4, 32'h8};
        run_fetches(1'b0);
        fq = '{32'hC};
        for (int i = 0; i < 12; i++) begin
            fq.push_back($urandom_range(0, 19) * 4 +
                         (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
        end
        run_fetches(1'b1);
    endtask

    task automatic test_flags();
        fq = '{32'h6, 32'h40, 32'h42, 32'h3C, 32'h4000_0000, 32'hFFFF_FFFC, 32'h0000_0101};
        for (int i = 0; i < 6; i++) fq.push_back($urandom);
        run_fetches(1'b1);
    endtask

    task automatic test_overflow();
        apply_reset();
        wait_clear();
        for (int i = 0; i < 20; i++) drive_ld(1'b1, $urandom, 1'b0);
        ld_valid = 1'b0;
        checks++;
        if (ld_ready !== 1'b0 || load_count !== 5'd16) begin
            failures++;
            $display("FAIL overflow_stop: ld_ready=%b load_count=%0d expected 0/16",
                     ld_ready, load_count);
        end
        for (int i = 0; i < DEPTH; i++) fq.push_back(i * 4);
        fq.push_back(32'h40);
        run_fetches(1'b0);
    endtask

    task automatic test_reset_async();
        apply_reset();
        wait_clear();
        drive_ld(1'b1, $urandom, 1'b0);
        drive_ld(1'b1, $urandom, 1'b0);
        #3;
        SYS_reset = 1'b1;
        #1;
        checks++;
        if (outs_all !== '0) begin
            failures++;
            $display("FAIL async_reset_load: got %h expected 0", outs_all);
        end
        ld_valid = 1'b0;
        step();
        SYS_reset = 1'b0;
        model_boot();
        wait_clear();
        drive_ld(1'b1, $urandom, 1'b1);
        ld_valid = 1'b0;
        // Word 1 held data before the reset; the restarted clear must have wiped it.
        fq = '{32'h0, 32'h4};
        run_fetches(1'b0);
        PC = 32'h0;
        fetch_req = 1'b1;
        #3;
        SYS_reset = 1'b1;
        #1;
        checks++;
        if (outs_all !== '0) begin
            failures++;
            $display("FAIL async_reset_fetch: got %h expected 0", outs_all);
        end
        step();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL inflight_drop: instr_valid=%b expected 0", instr_valid);
        end
        SYS_reset = 1'b0;
        step();
        checks++;
        if (instr_valid !== 1'b0 || boot_done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: instr_valid=%b boot_done=%b expected 0/0",
                     instr_valid, boot_done);
        end
        fetch_req = 1'b0;
        apply_reset();
        wait_clear();
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        drive_ld(1'b1, 32'h1234_5678, 1'b0);
        drive_ld(1'b1, 32'h0BAD_F00D, 1'b1);
        ld_valid = 1'b0;
        u_dut.u_array.mem_q[1][3] = ~u_dut.u_array.mem_q[1][3];
        PC = 32'h4;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++;
        if (parity_err !== 1'b1 || instruction !== NOP || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL parity_flip: perr=%b ins=%h valid=%b expected 1 %h 1",
                     parity_err, instruction, instr_valid, NOP);
        end
        fq = '{32'h0};
        run_fetches(1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_clear_single();
        test_load_stall();
        test_flags();
        test_overflow();
        test_reset_async();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
